// File: rtl/mm_job_sequencer.sv
// mm_job_sequencer
//   Command queue and dispatcher sitting in front of the matrix-multiply
//   engine. Jobs are buffered in a small FIFO, launched one at a time with a
//   single-cycle mm_start pulse, and their operands are held stable on mm_*
//   for the whole job. Each job produces exactly one tagged completion record
//   (ok / engine error / timeout / rejected).
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   cmd_*             job input (valid/ready), tag, M1/M2/M3, A/B/D addresses
//   timeout_cycles    WAIT-state limit in cycles, 0 disables the timeout
//   mm_start, mm_*    launch pulse and held operands towards the engine
//   mm_done, mm_error engine completion (error qualified by done)
//   cpl_*             completion record (valid/ready), tag and status
//   queue_level       FIFO occupancy
//   busy              dispatcher is not idle
//   halted            sticky timeout fault, cleared only by rst
//
// Handshakes (cmd_* and cpl_*): a transfer happens on a rising clk edge where
// valid and ready are both 1. The source keeps valid and its payload stable
// until that edge; ready never depends combinationally on valid.
module mm_job_sequencer #(
  parameter int MATRIXSIZE_W = 24,
  parameter int ADDR_W       = 64,
  parameter int TAG_W        = 8,
  parameter int QUEUE_DEPTH  = 4,
  parameter int TIMEOUT_W    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [TAG_W-1:0]             cmd_tag,
  input  logic [MATRIXSIZE_W-1:0]      cmd_M1,
  input  logic [MATRIXSIZE_W-1:0]      cmd_M2,
  input  logic [MATRIXSIZE_W-1:0]      cmd_M3,
  input  logic [ADDR_W-1:0]            cmd_addr_a,
  input  logic [ADDR_W-1:0]            cmd_addr_b,
  input  logic [ADDR_W-1:0]            cmd_addr_d,
  input  logic [TIMEOUT_W-1:0]         timeout_cycles,
  output logic                         mm_start,
  output logic [MATRIXSIZE_W-1:0]      mm_M1,
  output logic [MATRIXSIZE_W-1:0]      mm_M2,
  output logic [MATRIXSIZE_W-1:0]      mm_M3,
  output logic [ADDR_W-1:0]            mm_addr_matrix_a,
  output logic [ADDR_W-1:0]            mm_addr_matrix_b,
  output logic [ADDR_W-1:0]            mm_addr_matrix_d,
  input  logic                         mm_done,
  input  logic                         mm_error,
  output logic                         cpl_valid,
  input  logic                         cpl_ready,
  output logic [TAG_W-1:0]             cpl_tag,
  output logic [1:0]                   cpl_status,
  output logic [$clog2(QUEUE_DEPTH):0] queue_level,
  output logic                         busy,
  output logic                         halted
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERROR   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_REJECT  = 2'b11;

  typedef struct packed {
    logic [TAG_W-1:0]        tag;
    logic [MATRIXSIZE_W-1:0] m1;
    logic [MATRIXSIZE_W-1:0] m2;
    logic [MATRIXSIZE_W-1:0] m3;
    logic [ADDR_W-1:0]       a;
    logic [ADDR_W-1:0]       b;
    logic [ADDR_W-1:0]       d;
  } job_t;

  // State is kept as a named enum so checkers can bind to it directly.
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_REPORT} state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------- FIFO
  job_t             fifo_mem [QUEUE_DEPTH];
  job_t             cmd_job, head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic             push, pop, fifo_empty;

  assign cmd_job = '{tag: cmd_tag, m1: cmd_M1, m2: cmd_M2, m3: cmd_M3,
                     a: cmd_addr_a, b: cmd_addr_b, d: cmd_addr_d};
  assign head        = fifo_mem[rd_ptr];
  assign fifo_empty  = (level == '0);
  // Full check only; a pop in the same cycle does not open a slot early.
  assign cmd_ready   = (level != LVL_W'(QUEUE_DEPTH));
  assign push        = cmd_valid && cmd_ready;
  assign queue_level = level;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= cmd_job;
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic [TAG_W-1:0]     cur_tag;
  logic [TAG_W-1:0]     cpl_tag_nxt;
  logic [1:0]           cpl_status_nxt;
  logic                 latch_job, load_cpl, set_halt, tmo_hit, head_zero;

  assign head_zero = (head.m1 == '0) || (head.m2 == '0) || (head.m3 == '0);
  assign tmo_hit   = (timeout_cycles != '0) &&
                     (tmo_cnt == timeout_cycles - TIMEOUT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    pop            = 1'b0;
    latch_job      = 1'b0;
    load_cpl       = 1'b0;
    set_halt       = 1'b0;
    cpl_tag_nxt    = cur_tag;
    cpl_status_nxt = ST_OK;
    case (state)
      S_IDLE: begin
        if (!fifo_empty && !halted) begin
          pop = 1'b1;
          if (head_zero) begin
            // Degenerate job: report it without ever touching the engine.
            load_cpl       = 1'b1;
            cpl_tag_nxt    = head.tag;
            cpl_status_nxt = ST_REJECT;
            state_nxt      = S_REPORT;
          end else begin
            latch_job = 1'b1;
            state_nxt = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT: begin
        // done is checked first so it wins over a coincident timeout.
        if (mm_done) begin
          load_cpl       = 1'b1;
          cpl_status_nxt = mm_error ? ST_ERROR : ST_OK;
          state_nxt      = S_REPORT;
        end else if (tmo_hit) begin
          load_cpl       = 1'b1;
          cpl_status_nxt = ST_TIMEOUT;
          set_halt       = 1'b1;
          state_nxt      = S_REPORT;
        end
      end
      S_REPORT: begin
        if (cpl_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign mm_start  = (state == S_LAUNCH);
  assign cpl_valid = (state == S_REPORT);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mm_M1            <= '0;
      mm_M2            <= '0;
      mm_M3            <= '0;
      mm_addr_matrix_a <= '0;
      mm_addr_matrix_b <= '0;
      mm_addr_matrix_d <= '0;
      cur_tag          <= '0;
      cpl_tag          <= '0;
      cpl_status       <= '0;
      halted           <= 1'b0;
      tmo_cnt          <= '0;
    end else begin
      // Operands only move when a job is launched; they stay after it ends.
      if (latch_job) begin
        mm_M1            <= head.m1;
        mm_M2            <= head.m2;
        mm_M3            <= head.m3;
        mm_addr_matrix_a <= head.a;
        mm_addr_matrix_b <= head.b;
        mm_addr_matrix_d <= head.d;
        cur_tag          <= head.tag;
      end
      if (load_cpl) begin
        cpl_tag    <= cpl_tag_nxt;
        cpl_status <= cpl_status_nxt;
      end
      if (set_halt) halted <= 1'b1;
      if (state == S_LAUNCH)    tmo_cnt <= '0;
      else if (state == S_WAIT) tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
    end
  end

endmodule

// File: tb/tb_mm_job_sequencer.sv
`timescale 1ns/1ps
module tb_mm_job_sequencer;

  localparam int MW  = 24;
  localparam int AW  = 64;
  localparam int TW  = 8;
  localparam int QD  = 4;
  localparam int TMW = 32;

  // ------------------------------------------------------ clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [TW-1:0]  cmd_tag = '0;
  logic [MW-1:0]  cmd_M1 = '0, cmd_M2 = '0, cmd_M3 = '0;
  logic [AW-1:0]  cmd_addr_a = '0, cmd_addr_b = '0, cmd_addr_d = '0;
  logic [TMW-1:0] timeout_cycles = '0;
  logic           mm_start;
  logic [MW-1:0]  mm_M1, mm_M2, mm_M3;
  logic [AW-1:0]  mm_addr_matrix_a, mm_addr_matrix_b, mm_addr_matrix_d;
  logic           mm_done = 1'b0, mm_error = 1'b0;
  logic           cpl_valid;
  logic           cpl_ready = 1'b1;
  logic [TW-1:0]  cpl_tag;
  logic [1:0]     cpl_status;
  logic [2:0]     queue_level;
  logic           busy, halted;

  mm_job_sequencer #(
    .MATRIXSIZE_W(MW), .ADDR_W(AW), .TAG_W(TW), .QUEUE_DEPTH(QD), .TIMEOUT_W(TMW)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tag(cmd_tag),
    .cmd_M1(cmd_M1), .cmd_M2(cmd_M2), .cmd_M3(cmd_M3),
    .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_addr_d(cmd_addr_d),
    .timeout_cycles(timeout_cycles),
    .mm_start(mm_start), .mm_M1(mm_M1), .mm_M2(mm_M2), .mm_M3(mm_M3),
    .mm_addr_matrix_a(mm_addr_matrix_a), .mm_addr_matrix_b(mm_addr_matrix_b),
    .mm_addr_matrix_d(mm_addr_matrix_d),
    .mm_done(mm_done), .mm_error(mm_error),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_tag(cpl_tag),
    .cpl_status(cpl_status), .queue_level(queue_level), .busy(busy), .halted(halted)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------ reference model
  typedef struct packed {
    logic [TW-1:0] tag;
    logic [MW-1:0] m1, m2, m3;
    logic [AW-1:0] a, b, d;
  } job_t;

  localparam int P_IDLE = 0, P_START = 1, P_WAIT = 2, P_REPORT = 3;

  job_t          mq[$];            // jobs accepted but not yet taken
  logic [TW+1:0] exp_q[$];         // completions owed, {tag, status}
  job_t          cur = '0;         // operands presented to the engine
  job_t          m_j;
  int            phase = P_IDLE;
  int            waited = 0;       // completed WAIT cycles of the current job
  logic          m_halted = 1'b0;
  logic [TW-1:0] m_tag = '0;
  logic [1:0]    m_status = '0;
  logic          m_push;

  task automatic model_report(input logic [TW-1:0] t, input logic [1:0] s);
    m_tag    = t;
    m_status = s;
    phase    = P_REPORT;
    exp_q.push_back({t, s});
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      exp_q.delete();
      cur      = '0;
      phase    = P_IDLE;
      waited   = 0;
      m_halted = 1'b0;
      m_tag    = '0;
      m_status = '0;
    end else begin
      m_push = cmd_valid && (mq.size() != QD);
      case (phase)
        P_IDLE: if (mq.size() > 0 && !m_halted) begin
          m_j = mq.pop_front();
          if (m_j.m1 == 0 || m_j.m2 == 0 || m_j.m3 == 0) model_report(m_j.tag, 2'b11);
          else begin
            cur   = m_j;
            phase = P_START;
          end
        end
        P_START: begin
          phase  = P_WAIT;
          waited = 0;
        end
        P_WAIT: begin
          if (mm_done) model_report(cur.tag, mm_error ? 2'b01 : 2'b00);
          else if (timeout_cycles != 0 && waited + 1 == int'(timeout_cycles)) begin
            m_halted = 1'b1;
            model_report(cur.tag, 2'b10);
          end else waited++;
        end
        default: if (cpl_ready) phase = P_IDLE;
      endcase
      // A job pushed this edge is not visible to the dispatcher until next edge.
      if (m_push) mq.push_back('{tag: cmd_tag, m1: cmd_M1, m2: cmd_M2, m3: cmd_M3,
                                 a: cmd_addr_a, b: cmd_addr_b, d: cmd_addr_d});
    end
  end

  // ------------------------------------------------------ scoreboard
  int            n_starts = 0;
  logic [TW+1:0] got[$];
  logic [TW+1:0] e_cpl;

  always @(negedge clk) begin
    chk("queue_level", queue_level, mq.size());
    chk("cmd_ready", cmd_ready, mq.size() != QD);
    chk("busy", busy, phase != P_IDLE);
    chk("mm_start", mm_start, phase == P_START);
    chk("halted", halted, m_halted);
    chk("cpl_valid", cpl_valid, phase == P_REPORT);
    chk("mm_M1", mm_M1, cur.m1);
    chk("mm_M2", mm_M2, cur.m2);
    chk("mm_M3", mm_M3, cur.m3);
    chk("mm_addr_a", mm_addr_matrix_a, cur.a);
    chk("mm_addr_b", mm_addr_matrix_b, cur.b);
    chk("mm_addr_d", mm_addr_matrix_d, cur.d);
    if (phase == P_REPORT) begin
      chk("cpl_tag", cpl_tag, m_tag);
      chk("cpl_status", cpl_status, m_status);
    end
    if (mm_start) n_starts++;
    if (cpl_valid && cpl_ready) begin
      got.push_back({cpl_tag, cpl_status});
      chk("cpl owed", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e_cpl = exp_q.pop_front();
        chk("cpl record", {cpl_tag, cpl_status}, e_cpl);
      end
    end
  end

  // ------------------------------------------------------ driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [TW-1:0] t, input logic [MW-1:0] m1,
                         input logic [MW-1:0] m2, input logic [MW-1:0] m3,
                         input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] d);
    cmd_tag = t; cmd_M1 = m1; cmd_M2 = m2; cmd_M3 = m3;
    cmd_addr_a = a; cmd_addr_b = b; cmd_addr_d = d;
    cmd_valid = 1'b1;
  endtask

  // n = cycle in which the push was presented and accepted
  task automatic push_job(input logic [TW-1:0] t, input logic [MW-1:0] m1,
                          input logic [MW-1:0] m2, input logic [MW-1:0] m3,
                          input logic [AW-1:0] a, input logic [AW-1:0] b,
                          input logic [AW-1:0] d, output int n);
    logic ok;
    ok = 1'b0;
    n  = -1;
    set_cmd(t, m1, m2, m3, a, b, d);
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        n  = cyc;
        tick();
        break;
      end
      tick();
    end
    cmd_valid = 1'b0;
    chk("push accepted", ok, 1);
  endtask

  task automatic wait_start(output int c, input int max);
    logic seen;
    seen = 1'b0;
    c    = -1;
    for (int i = 0; i < max; i++) begin
      if (mm_start) begin
        seen = 1'b1;
        c    = cyc;
        break;
      end
      tick();
    end
    chk("start seen", seen, 1);
  endtask

  task automatic wait_cpl(output logic [TW-1:0] t, output logic [1:0] s,
                          output int c, input int max);
    logic seen;
    seen = 1'b0;
    t = '0; s = '0; c = -1;
    for (int i = 0; i < max; i++) begin
      if (cpl_valid) begin
        seen = 1'b1;
        t = cpl_tag; s = cpl_status; c = cyc;
        break;
      end
      tick();
    end
    chk("cpl seen", seen, 1);
  endtask

  task automatic pulse_done(input logic err);
    mm_done  = 1'b1;
    mm_error = err;
    tick();
    mm_done  = 1'b0;
    mm_error = 1'b0;
  endtask

  // ------------------------------------------------------ directed tests
  int            n, s, c, st0;
  logic [TW-1:0] t;
  logic [1:0]    st;
  logic [TW+1:0] e;
  logic          rdy_seen;

  initial begin
    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst cmd_ready", cmd_ready, 1);
    chk("rst queue_level", queue_level, 0);
    chk("rst busy", busy, 0);
    chk("rst cpl_valid", cpl_valid, 0);
    chk("rst mm_addr_d", mm_addr_matrix_d, 0);
    rst = 1'b0;
    tick();

    // stray done while idle is dropped
    mm_done = 1'b1; mm_error = 1'b1;
    tick();
    mm_done = 1'b0; mm_error = 1'b0;
    tick();
    chk("stray done cpl_valid", cpl_valid, 0);
    chk("stray done busy", busy, 0);

    // single job
    push_job(8'h11, 8, 8, 8, 64'h1000, 64'h2000, 64'h3000, n);
    wait_start(s, 10);
    chk("t1 start latency", s, n + 2);
    chk("t1 mm_M1", mm_M1, 8);
    chk("t1 mm_M3", mm_M3, 8);
    chk("t1 addr a", mm_addr_matrix_a, 64'h1000);
    chk("t1 addr b", mm_addr_matrix_b, 64'h2000);
    chk("t1 addr d", mm_addr_matrix_d, 64'h3000);
    repeat (50) tick();
    pulse_done(1'b0);
    chk("t1 cpl_valid", cpl_valid, 1);
    chk("t1 cpl_tag", cpl_tag, 8'h11);
    chk("t1 cpl_status", cpl_status, 2'b00);
    tick();
    chk("t1 cpl dropped", cpl_valid, 0);
    chk("t1 back to idle", busy, 0);
    chk("t1 operands held", mm_addr_matrix_b, 64'h2000);

    // five jobs against a busy engine
    push_job(8'hA0, 9, 9, 9, 64'hA000, 64'hB000, 64'hD000, n);
    wait_start(s, 10);
    for (int k = 0; k < 4; k++)
      push_job(8'(k), MW'(k + 1), MW'(k + 2), MW'(k + 3), AW'(k), AW'(k), AW'(k), n);
    chk("t2 full level", queue_level, 4);
    chk("t2 full ready", cmd_ready, 0);
    set_cmd(8'd4, 5, 6, 7, 4, 4, 4);
    tick();
    chk("t2 fifth held off", cmd_ready, 0);
    got.delete();
    pulse_done(1'b0);
    rdy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin
        rdy_seen = 1'b1;
        chk("t2 level after pop", queue_level, 3);
        chk("t2 tag0 launching", mm_start, 1);
        chk("t2 tag0 M1", mm_M1, 1);
        tick();
        break;
      end
      tick();
    end
    cmd_valid = 1'b0;
    chk("t2 fifth accepted", rdy_seen, 1);
    chk("t2 level refilled", queue_level, 4);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        wait_start(s, 50);
        chk("t2 job M1", mm_M1, k + 1);
      end
      repeat (3) tick();
      pulse_done(1'b0);
    end
    repeat (3) tick();
    chk("t2 cpl count", got.size(), 6);
    if (got.size() == 6) begin
      chk("t2 first cpl", got[0], {8'hA0, 2'b00});
      for (int i = 1; i < 6; i++) begin
        e = {8'(i - 1), 2'b00};
        chk("t2 cpl order", got[i], e);
      end
    end

    // zero dimension rejected, next job dispatches
    st0 = n_starts;
    push_job(8'h30, 4, 0, 4, 64'h10, 64'h20, 64'h30, n);
    push_job(8'h31, 3, 5, 7, 64'h40, 64'h50, 64'h60, s);
    wait_cpl(t, st, c, 10);
    chk("t3 reject tag", t, 8'h30);
    chk("t3 reject status", st, 2'b11);
    chk("t3 reject latency", c, n + 2);
    chk("t3 no start", n_starts, st0);
    wait_start(s, 10);
    chk("t3 next start cycle", s, n + 4);
    chk("t3 next M2", mm_M2, 5);
    chk("t3 next addr d", mm_addr_matrix_d, 64'h60);
    repeat (5) tick();
    pulse_done(1'b0);
    wait_cpl(t, st, c, 5);
    chk("t3 next tag", t, 8'h31);
    chk("t3 next status", st, 2'b00);
    tick();

    // engine error with completion backpressure
    push_job(8'h40, 5, 6, 7, 64'h100, 64'h200, 64'h300, n);
    push_job(8'h41, 2, 2, 2, 64'h400, 64'h500, 64'h600, n);
    wait_start(s, 10);
    repeat (4) tick();
    cpl_ready = 1'b0;
    pulse_done(1'b1);
    st0 = n_starts;
    for (int i = 0; i < 10; i++) begin
      chk("t4 cpl_valid held", cpl_valid, 1);
      chk("t4 cpl_tag held", cpl_tag, 8'h40);
      chk("t4 cpl_status held", cpl_status, 2'b01);
      chk("t4 no launch", mm_start, 0);
      tick();
    end
    cpl_ready = 1'b1;
    tick();
    chk("t4 cpl released", cpl_valid, 0);
    chk("t4 no start during stall", n_starts, st0);
    wait_start(s, 10);
    chk("t4 next M1", mm_M1, 2);
    repeat (2) tick();
    pulse_done(1'b0);
    wait_cpl(t, st, c, 5);
    chk("t4 next tag", t, 8'h41);
    tick();

    // done coincident with the timeout cycle: done wins
    timeout_cycles = 100;
    push_job(8'h60, 1, 1, 1, 64'h1, 64'h2, 64'h3, n);
    wait_start(s, 10);
    repeat (100) tick();
    pulse_done(1'b0);
    wait_cpl(t, st, c, 5);
    chk("t5 coincident status", st, 2'b00);
    chk("t5 coincident halted", halted, 0);
    tick();

    // real timeout
    push_job(8'h50, 2, 3, 4, 64'h7, 64'h8, 64'h9, n);
    wait_start(s, 10);
    wait_cpl(t, st, c, 200);
    chk("t5 timeout cycle", c, s + 101);
    chk("t5 timeout tag", t, 8'h50);
    chk("t5 timeout status", st, 2'b10);
    chk("t5 halted", halted, 1);
    tick();
    st0 = n_starts;
    for (int k = 0; k < 4; k++)
      push_job(8'h51 + 8'(k), 1, 2, 3, 64'h0, 64'h0, 64'h0, n);
    repeat (20) tick();
    chk("t5 halted queue fills", queue_level, 4);
    chk("t5 halted ready", cmd_ready, 0);
    chk("t5 halted no start", n_starts, st0);
    chk("t5 halted idle", busy, 0);
    rst = 1'b1;
    #1;
    chk("t5 rst clears halted", halted, 0);
    chk("t5 rst clears queue", queue_level, 0);
    tick();
    tick();
    rst = 1'b0;
    timeout_cycles = 0;
    tick();

    // asynchronous reset during WAIT with 3 jobs queued
    push_job(8'h70, 4, 4, 4, 64'hAA, 64'hBB, 64'hCC, n);
    wait_start(s, 10);
    for (int k = 0; k < 3; k++)
      push_job(8'h71 + 8'(k), 3, 3, 3, 64'h1, 64'h1, 64'h1, n);
    tick();
    chk("t6 queued before rst", queue_level, 3);
    chk("t6 busy before rst", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6 async busy", busy, 0);
    chk("t6 async queue_level", queue_level, 0);
    chk("t6 async cmd_ready", cmd_ready, 1);
    chk("t6 async mm_M1", mm_M1, 0);
    chk("t6 async addr a", mm_addr_matrix_a, 0);
    chk("t6 async cpl_valid", cpl_valid, 0);
    tick();
    tick();
    rst = 1'b0;
    st0 = n_starts;
    c = got.size();
    pulse_done(1'b0);
    repeat (20) tick();
    chk("t6 no completion", got.size(), c);
    chk("t6 no start", n_starts, st0);
    chk("t6 queue empty", queue_level, 0);
    chk("t6 owed drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_chk++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mm_job_sequencer.md
Name: mm_job_sequencer

Overview:
- Command queue and dispatcher directly upstream of the matrix-multiply engine's control interface (start/done/error, M1/M2/M3, matrix A/B/D addresses).
- Buffers matmul jobs, launches them one at a time with a single-cycle start pulse, and holds job operands stable for the whole job.
- Watches done/error with a timeout and returns one tagged completion record per job, so upstream BERT-layer control can chain matmuls without polling.

Parameters:
- MATRIXSIZE_W, 24, width of M1/M2/M3.
- ADDR_W, 64, width of matrix base addresses.
- TAG_W, 8, width of job tag.
- QUEUE_DEPTH, 4, command FIFO entries (power of 2, >=2).
- TIMEOUT_W, 32, width of timeout counter and timeout_cycles.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  job offered.
- cmd_ready  out  1  queue can accept.
- cmd_tag  in  TAG_W  job tag.
- cmd_M1, cmd_M2, cmd_M3  in  MATRIXSIZE_W each  matrix dimensions.
- cmd_addr_a, cmd_addr_b, cmd_addr_d  in  ADDR_W each  matrix base addresses.
- timeout_cycles  in  TIMEOUT_W  WAIT-state limit; 0 disables the timeout.
- mm_start  out  1  one-cycle launch pulse to the engine.
- mm_M1, mm_M2, mm_M3  out  MATRIXSIZE_W each  held job dimensions.
- mm_addr_matrix_a, mm_addr_matrix_b, mm_addr_matrix_d  out  ADDR_W each  held job addresses.
- mm_done  in  1  engine completion.
- mm_error  in  1  engine error, qualified by mm_done.
- cpl_valid  out  1  completion record valid.
- cpl_ready  in  1  completion accepted.
- cpl_tag  out  TAG_W  tag of completed job.
- cpl_status  out  2  00 ok, 01 engine error, 10 timeout, 11 rejected (zero dimension).
- queue_level  out  clog2(QUEUE_DEPTH)+1  FIFO occupancy.
- busy  out  1  FSM not in IDLE.
- halted  out  1  sticky timeout fault.

Behaviour:
- Reset values: all outputs 0, except cmd_ready=1. FSM=IDLE, FIFO empty, timeout counter 0.
- FIFO:
  - Push on cmd_valid&&cmd_ready.
  - cmd_ready = (queue_level != QUEUE_DEPTH); it does not look ahead to a same-cycle pop.
  - A pushed entry is visible to the FSM the cycle after the push.
  - Simultaneous push and pop is legal; level is unchanged.
  - Pointers wrap modulo QUEUE_DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty and !halted, pop the head.
    - If any of M1/M2/M3 == 0, go to REPORT with status 11; no start is issued.
    - Otherwise latch the job into the mm_* registers and go to LAUNCH.
  - LAUNCH: mm_start=1 for exactly this cycle; clear the timeout counter; go to WAIT.
  - WAIT: timeout counter increments every cycle.
    - If mm_done=1: status = mm_error ? 01 : 00, go to REPORT.
    - Else if timeout_cycles!=0 and counter == timeout_cycles-1: status 10, set halted, go to REPORT.
    - If mm_done and the timeout hit occur in the same cycle, done wins.
  - REPORT: cpl_valid=1; cpl_tag and cpl_status are stable while cpl_valid=1 and cpl_ready=0.
    - On cpl_ready, drop cpl_valid next cycle and go to IDLE.
- Latency: a push at cycle N into an empty queue, with FSM in IDLE, gives mm_start high at N+2. A completion, when cpl_ready is held high, is visible one cycle after mm_done and lasts one cycle. The FSM returns to IDLE the cycle after that.
- Operand hold: mm_M*/mm_addr_* change only on the IDLE->LAUNCH transition; they hold their values after the job ends.
- mm_done and mm_error are ignored outside WAIT; a stray done is dropped.
- Halted: the FIFO still accepts pushes until full, but no further jobs are dispatched. Only rst clears halted.
- Reset mid-operation: asynchronous return to reset values. Queued jobs are discarded, and no completion is produced for an in-flight job.
- busy=1 in LAUNCH, WAIT and REPORT.

Test Plan:
- Single job (tag 0x11, M1=M2=M3=8, A=0x1000, B=0x2000, D=0x3000) pushed at cycle N: mm_start pulse at N+2 with those operands; mm_done 50 cycles later -> cpl_tag=0x11, cpl_status=00.
- Push 5 jobs back-to-back with QUEUE_DEPTH=4 while the engine is busy: cmd_ready drops after 4 entries, the fifth is accepted after the first pop, and completions arrive in order with tags 0..4.
- Job with M2=0 -> no mm_start; cpl_status=11; the next queued job dispatches normally.
- mm_done with mm_error=1 -> cpl_status=01. Then cpl_ready held low for 10 cycles: cpl_valid, cpl_tag and cpl_status stay stable and no new mm_start is issued.
- timeout_cycles=100 with mm_done never asserted -> cpl_status=10 exactly 100 cycles after entering WAIT; halted=1; a queued job is not launched until rst. Also check: mm_done coincident with the timeout cycle -> status 00, halted stays 0.
- rst asserted during WAIT with 3 jobs queued -> all outputs return to reset values asynchronously; queue_level=0; no cpl_valid follows.
